muladd_result_unpacker: RTL and testbench

Downstream stage of MulAdd_top, on the clk_data domain. It captures the packed 32-bit result stream (result_valid/result_payload, two 16-bit results per word) into a small FIFO and re-emits it as a 16-bit-per-element valid/ready stream with frame boundaries. MulAdd_top has no backpressure, so this block absorbs bursts and flags any loss with a sticky overflow flag.

---
 rtl/muladd_pkg.sv | 11 +
 rtl/muladd_sync_fifo.sv | 58 +++++
 rtl/muladd_result_unpacker.sv | 101 ++++++++++
 tb/tb_muladd_result_unpacker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/muladd_pkg.sv
// Shared constants and element/word types for the MulAdd result path.
package muladd_pkg;

    localparam int DATA_W    = 16;
    localparam int PAYLOAD_W = 2 * DATA_W;
    localparam int FRAME_LEN = 256;

    typedef logic [DATA_W-1:0]    result_elem_t;
    typedef logic [PAYLOAD_W-1:0] result_word_t;

endpackage

// File: rtl/muladd_sync_fifo.sv
// Single-clock first-word fall-through FIFO. The head entry is visible on
// head_o whenever empty_o is low. A push while full is accepted only when a
// pop happens in the same cycle, which frees the slot being written.
module muladd_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign level_o = count;
    assign head_o  = mem[rd_ptr];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage array; no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/muladd_result_unpacker.sv
// Buffers packed two-element result words from MulAdd_top and re-emits them
// as a one-element-per-transfer valid/ready stream with frame markers.
// The producer cannot be stalled, so a full FIFO drops words and latches a
// sticky overflow flag.
module muladd_result_unpacker
    import muladd_pkg::*;
#(
    parameter int DATA_W     = muladd_pkg::DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = muladd_pkg::FRAME_LEN
) (
    input  logic                          clk_data,
    input  logic                          rst_n,
    input  logic                          result_valid_i,
    input  logic [2*DATA_W-1:0]           result_payload_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_W-1:0]             out_data_o,
    output logic                          out_last_o,
    output logic                          frame_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    input  logic                          clear_ovf_i
);

    localparam int CW = $clog2(FRAME_LEN);

    // Half-select FSM: which half of the head word is presented.
    localparam logic [0:0] HALF_HIGH = 1'b1;
    localparam logic [0:0] HALF_LOW  = 1'b0;

    logic [0:0]          half_q;
    logic [CW-1:0]       elem_cnt;
    logic [2*DATA_W-1:0] head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                xfer;
    logic                pop;
    logic                drop;
    logic                at_last;

    assign out_valid_o = ~fifo_empty;
    assign xfer        = out_valid_o & out_ready_i;
    assign pop         = xfer & (half_q == HALF_LOW);
    // Full FIFO only takes the word if the low half leaves this cycle.
    assign drop        = result_valid_i & fifo_full & ~pop;
    assign at_last     = (elem_cnt == CW'(FRAME_LEN - 1));

    // Gate with valid so the idle output is a clean zero, not stale memory.
    assign out_data_o  = fifo_empty           ? '0 :
                         (half_q == HALF_HIGH) ? head[2*DATA_W-1:DATA_W]
                                               : head[DATA_W-1:0];
    assign out_last_o  = out_valid_o & at_last;

    muladd_sync_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk_data),
        .rst_n       (rst_n),
        .push_i      (result_valid_i),
        .push_data_i (result_payload_i),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level_o)
    );

    // Flip between high and low half on every accepted element.
    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) begin
            half_q <= HALF_HIGH;
        end else if (xfer) begin
            half_q <= (half_q == HALF_HIGH) ? HALF_LOW : HALF_HIGH;
        end
    end

    // Element position within the frame; wraps after the last element.
    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt <= '0;
        end else if (xfer) begin
            elem_cnt <= at_last ? '0 : elem_cnt + CW'(1);
        end
    end

    // One-cycle pulse after the final element of a frame is accepted.
    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) frame_done_o <= 1'b0;
        else        frame_done_o <= xfer & at_last;
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n)           overflow_o <= 1'b0;
        else if (drop)        overflow_o <= 1'b1;
        else if (clear_ovf_i) overflow_o <= 1'b0;
    end

endmodule

// File: tb/tb_muladd_result_unpacker.sv
// Directed bench for muladd_result_unpacker: reset, ordering, stall,
// frame marking, overflow and mid-frame reset.
module tb_muladd_result_unpacker;
    import muladd_pkg::*;

    logic         clk_data = 1'b0;
    logic         rst_n;
    logic         result_valid_i;
    result_word_t result_payload_i;
    logic         out_valid_o;
    logic         out_ready_i;
    result_elem_t out_data_o;
    logic         out_last_o;
    logic         frame_done_o;
    logic [4:0]   fifo_level_o;
    logic         overflow_o;
    logic         clear_ovf_i;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_data = ~clk_data;

    muladd_result_unpacker dut (
        .clk_data         (clk_data),
        .rst_n            (rst_n),
        .result_valid_i   (result_valid_i),
        .result_payload_i (result_payload_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_data_o       (out_data_o),
        .out_last_o       (out_last_o),
        .frame_done_o     (frame_done_o),
        .fifo_level_o     (fifo_level_o),
        .overflow_o       (overflow_o),
        .clear_ovf_i      (clear_ovf_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_data);
        rst_n = 1'b0; result_valid_i = 1'b0; out_ready_i = 1'b0; clear_ovf_i = 1'b0;
        @(negedge clk_data);
        rst_n = 1'b1;
    endtask

    task automatic push_word(input result_word_t w);
        @(negedge clk_data);
        result_valid_i = 1'b1; result_payload_i = w;
    endtask

    // Push nwords pattern words {2n, 2n+1} at the drain rate while checking
    // every emitted element against a running index; ready held high.
    task automatic stream(input int nwords, output int nelem, output int ndone);
        int idx;
        idx = 0; ndone = 0;
        out_ready_i = 1'b1;
        fork
            begin
                for (int n = 0; n < nwords; n++) begin
                    @(negedge clk_data);
                    result_valid_i = 1'b1;
                    result_payload_i = {16'(2*n), 16'(2*n+1)};
                    @(negedge clk_data);
                    result_valid_i = 1'b0;
                end
            end
            begin
                for (int c = 0; c < 2*nwords + 10; c++) begin
                    @(negedge clk_data);
                    if (frame_done_o) begin
                        ndone++;
                        chk("frame_done_after_last", 32'(idx % 256), 32'd0);
                    end
                    if (out_valid_o) begin
                        chk("stream_data", 32'(out_data_o), 32'(16'(idx)));
                        chk("stream_last", 32'(out_last_o), 32'((idx % 256) == 255));
                        idx++;
                    end
                end
            end
        join
        nelem = idx;
    endtask

    initial begin
        result_elem_t got [8];
        int k, nelem, ndone;

        // Reset check: inputs active while held in reset
        rst_n = 1'b0; result_valid_i = 1'b1; result_payload_i = 32'h1234_5678;
        out_ready_i = 1'b1; clear_ovf_i = 1'b0;
        repeat (3) @(negedge clk_data);
        chk("rst_valid", 32'(out_valid_o), 0);
        chk("rst_data", 32'(out_data_o), 0);
        chk("rst_last", 32'(out_last_o), 0);
        chk("rst_done", 32'(frame_done_o), 0);
        chk("rst_level", 32'(fifo_level_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        rst_n = 1'b1; result_valid_i = 1'b0;
        repeat (2) @(negedge clk_data);
        chk("post_rst_valid", 32'(out_valid_o), 0);
        chk("post_rst_level", 32'(fifo_level_o), 0);

        // Order check
        do_reset();
        out_ready_i = 1'b1;
        push_word(32'hAAAA_5555);
        chk("order_not_yet", 32'(out_valid_o), 0);
        @(negedge clk_data); result_valid_i = 1'b0;
        chk("order_v0", 32'(out_valid_o), 1);
        chk("order_d0", 32'(out_data_o), 32'hAAAA);
        chk("order_l0", 32'(fifo_level_o), 1);
        @(negedge clk_data);
        chk("order_v1", 32'(out_valid_o), 1);
        chk("order_d1", 32'(out_data_o), 32'h5555);
        chk("order_l1", 32'(fifo_level_o), 1);
        @(negedge clk_data);
        chk("order_v2", 32'(out_valid_o), 0);
        chk("order_l2", 32'(fifo_level_o), 0);

        // Stall check
        do_reset();
        for (int i = 0; i < 4; i++) push_word({16'(2*i+1), 16'(2*i+2)});
        @(negedge clk_data); result_valid_i = 1'b0;
        chk("stall_level", 32'(fifo_level_o), 4);
        chk("stall_data", 32'(out_data_o), 32'h0001);
        @(negedge clk_data);
        chk("stall_hold", 32'(out_data_o), 32'h0001);
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge clk_data);
            out_ready_i = ~out_ready_i;
            if (out_valid_o && out_ready_i) begin
                got[k] = out_data_o;
                k++;
            end
        end
        chk("stall_count", 32'(k), 8);
        for (int i = 0; i < 8; i++) chk("stall_elem", 32'(got[i]), 32'(i+1));
        @(negedge clk_data); @(negedge clk_data); out_ready_i = 1'b0;
        chk("stall_empty", 32'(fifo_level_o), 0);

        // Frame check: two frames so the wrap to count 0 is exercised
        do_reset();
        stream(256, nelem, ndone);
        chk("frame_elems", 32'(nelem), 512);
        chk("frame_done_cnt", 32'(ndone), 2);

        // Overflow check
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_data);
            if (i == 16) begin
                chk("ovf_level16", 32'(fifo_level_o), 16);
                chk("ovf_not_yet", 32'(overflow_o), 0);
            end
            result_valid_i = 1'b1;
            result_payload_i = {16'(16'hB000 + 2*i), 16'(16'hB001 + 2*i)};
        end
        @(negedge clk_data);
        chk("ovf_set", 32'(overflow_o), 1);
        chk("ovf_level", 32'(fifo_level_o), 16);
        clear_ovf_i = 1'b1;                 // clear collides with another drop
        @(negedge clk_data);
        chk("ovf_drop_wins", 32'(overflow_o), 1);
        result_valid_i = 1'b0;
        @(negedge clk_data);
        chk("ovf_cleared", 32'(overflow_o), 0);
        clear_ovf_i = 1'b0; out_ready_i = 1'b1;
        chk("full_hi", 32'(out_data_o), 32'hB000);
        @(negedge clk_data);
        chk("full_lo", 32'(out_data_o), 32'hB001);
        result_valid_i = 1'b1; result_payload_i = 32'hDEAD_BEEF;
        @(negedge clk_data);
        result_valid_i = 1'b0; out_ready_i = 1'b0;
        chk("full_swap_level", 32'(fifo_level_o), 16);
        chk("full_swap_ovf", 32'(overflow_o), 0);
        chk("full_next_head", 32'(out_data_o), 32'hB002);
        out_ready_i = 1'b1;
        k = 0;
        while (out_valid_o && k < 60) begin
            @(negedge clk_data);
            k++;
        end
        chk("ovf_drained", 32'(fifo_level_o), 0);

        // Mid-operation reset with the frame counter away from zero
        do_reset();
        push_word(32'h0BAD_0BEE);
        @(negedge clk_data); result_valid_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clk_data); out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h5000_0000 + 32'(i));
        @(negedge clk_data); result_valid_i = 1'b0;
        chk("mid_level5", 32'(fifo_level_o), 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(fifo_level_o), 0);
        chk("mid_rst_valid", 32'(out_valid_o), 0);
        @(negedge clk_data); rst_n = 1'b1;
        stream(128, nelem, ndone);
        chk("mid_elems", 32'(nelem), 256);
        chk("mid_done_cnt", 32'(ndone), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
